exp_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one registered exponential lookup table (exptab, 1-cycle read latency) between NREQ operator requesters in the FM voice engine.
- Each requester submits a log-domain attenuation word. The block splits it into table address (mantissa) and shift count (exponent), drives the table, and barrel-shifts the result.
- It returns a linear magnitude tagged with the requester ID through a fixed-latency pipeline.

---
 rtl/exp_pkg.sv | 16 +
 rtl/rr_arb.sv | 30 +++
 rtl/exp_arb.sv | 82 ++++++++
 tb/tb_exp_arb.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/exp_pkg.sv
// exp_pkg: default widths and log-word helpers shared by the exp_arb slice.
package exp_pkg;
    localparam int NREQ_DEF = 4;
    localparam int IDW_DEF  = 2;
    localparam int ASZ_DEF  = 8;
    localparam int OSZ_DEF  = 10;
    localparam int LSZ_DEF  = 12;
    localparam int DSZ_DEF  = 14;
    function automatic int align_sh(int d, int o);
        return d - o - 1;
    endfunction
    localparam int ALIGN_SH = align_sh(DSZ_DEF, OSZ_DEF);
    function automatic logic [31:0] log_field(logic [31:0] w, int lo, int n);
        return (w >> lo) & ((32'd1 << n) - 32'd1);
    endfunction
endpackage

// File: rtl/rr_arb.sv
// rr_arb: round-robin one-hot grant, searching from the requester after the last winner.
module rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  id_o,
    output logic            valid_o
);
    logic [IDW-1:0] last_q, last_d;
    always_comb begin
        grant_o = '0;
        id_o    = '0;
        valid_o = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!valid_o && req_i[(int'(last_q) + k) % NREQ]) begin
                valid_o = 1'b1;
                grant_o[(int'(last_q) + k) % NREQ] = 1'b1;
                id_o = IDW'((int'(last_q) + k) % NREQ);
            end
        end
    end
    assign last_d = valid_o ? id_o : last_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) last_q <= IDW'(NREQ - 1);
        else last_q <= last_d;
endmodule

// File: rtl/exp_arb.sv
// exp_arb: shares one registered exp table among requesters; returns the
// barrel-shifted linear magnitude tagged with the requester id, 3 cycles after accept.
module exp_arb
    import exp_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = IDW_DEF,
    parameter int asz  = ASZ_DEF,
    parameter int osz  = OSZ_DEF,
    parameter int lsz  = LSZ_DEF,
    parameter int dsz  = DSZ_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*lsz-1:0]  req_log,
    output logic [NREQ-1:0]      req_ready,
    output logic [asz-1:0]       tab_addr,
    input  logic [osz-1:0]       tab_expo,
    output logic                 out_valid,
    output logic [IDW-1:0]       out_id,
    output logic [dsz-1:0]       out_lin
);
    localparam int EW = lsz - asz;
    localparam int SH = align_sh(dsz, osz);
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            gnt_v, acc;
    logic [lsz-1:0]  acc_log;
    logic [asz-1:0]  tab_addr_q;
    logic [EW-1:0]   s1_exp_q, s2_exp_q;
    logic [IDW-1:0]  s1_id_q, s2_id_q, out_id_q;
    logic            s1_v_q, s2_v_q, out_valid_q;
    logic [dsz-1:0]  m, lin_d, out_lin_q;
    rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .clk     (clk),
        .rst     (reset),
        .req_i   (req_valid),
        .grant_o (gnt),
        .id_o    (gnt_id),
        .valid_o (gnt_v)
    );
    assign req_ready = reset ? '0 : gnt;
    assign acc       = gnt_v & ~reset;
    assign acc_log   = req_log[int'(gnt_id)*lsz +: lsz];
    // Hidden leading one restored, then left-aligned so exponent 0 is full scale.
    assign m     = dsz'({1'b1, tab_expo}) << SH;
    assign lin_d = (int'(s2_exp_q) >= dsz) ? '0 : m >> s2_exp_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tab_addr_q  <= '0;
            s1_exp_q    <= '0;
            s1_id_q     <= '0;
            s1_v_q      <= 1'b0;
            s2_exp_q    <= '0;
            s2_id_q     <= '0;
            s2_v_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_lin_q   <= '0;
        end else begin
            if (acc) begin
                tab_addr_q <= asz'(log_field(32'(acc_log), 0, asz));
                s1_exp_q   <= EW'(log_field(32'(acc_log), asz, EW));
                s1_id_q    <= gnt_id;
            end
            s1_v_q      <= acc;
            s2_exp_q    <= s1_exp_q;
            s2_id_q     <= s1_id_q;
            s2_v_q      <= s1_v_q;
            out_valid_q <= s2_v_q;
            if (s2_v_q) begin
                out_id_q  <= s2_id_q;
                out_lin_q <= lin_d;
            end
        end
    end
    assign tab_addr  = tab_addr_q;
    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_lin   = out_lin_q;
endmodule

// File: tb/tb_exp_arb.sv
// tb_exp_arb: scoreboard bench for exp_arb with a registered addr<<2 table model.
module tb_exp_arb;
    typedef struct {
        int          id;
        logic [13:0] lin;
        int          due;
    } exp_t;
    logic        clk, reset;
    logic [3:0]  req_valid, req_ready;
    logic [47:0] req_log;
    logic [7:0]  tab_addr;
    logic [9:0]  tab_expo;
    logic        out_valid;
    logic [1:0]  out_id;
    logic [13:0] out_lin;
    exp_t        q[$];
    int          compared = 0, mismatched = 0, cyc = 0;
    exp_arb dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_log   (req_log),
        .req_ready (req_ready),
        .tab_addr  (tab_addr),
        .tab_expo  (tab_expo),
        .out_valid (out_valid),
        .out_id    (out_id),
        .out_lin   (out_lin)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) tab_expo <= {tab_addr, 2'b00};
    function automatic logic [13:0] model(logic [11:0] lw);
        logic [13:0] mm;
        mm = 14'({1'b1, lw[7:0], 2'b00}) << 3;
        return (lw[11:8] >= 4'd14) ? 14'd0 : mm >> lw[11:8];
    endfunction
    // Called at a falling edge with inputs already driven; ends at the next falling edge.
    task automatic step();
        exp_t e;
        logic ev;
        #2;
        for (int i = 0; i < 4; i++)
            if (req_valid[i] && req_ready[i])
                q.push_back('{i, model(req_log[i*12 +: 12]), cyc + 3});
        @(negedge clk);
        cyc++;
        ev = (q.size() > 0) && (q[0].due == cyc);
        compared++;
        if (out_valid !== ev) begin
            mismatched++;
            $display("FAIL out_valid cyc=%0d got %b want %b", cyc, out_valid, ev);
        end
        if (ev) begin
            e = q.pop_front();
            if (out_valid) begin
                compared += 2;
                if (out_id !== 2'(e.id)) begin
                    mismatched++;
                    $display("FAIL out_id cyc=%0d got %0d want %0d", cyc, out_id, e.id);
                end
                if (out_lin !== e.lin) begin
                    mismatched++;
                    $display("FAIL out_lin cyc=%0d got %h want %h", cyc, out_lin, e.lin);
                end
            end
        end
    endtask
    task automatic drive(input logic [3:0] v, input logic [3:0] want_rdy);
        req_valid = v;
        #1;
        compared++;
        if (req_ready !== want_rdy) begin
            mismatched++;
            $display("FAIL req_ready cyc=%0d got %b want %b", cyc, req_ready, want_rdy);
        end
        step();
    endtask
    task automatic idle(input int n);
        req_valid = 4'b0;
        for (int i = 0; i < n; i++) step();
    endtask
    task automatic check_zero(input string tag);
        compared++;
        if ({req_ready, tab_addr, out_valid, out_id, out_lin} !== 29'd0) begin
            mismatched++;
            $display("FAIL %s rdy=%b addr=%h v=%b id=%0d lin=%h want all 0", tag, req_ready, tab_addr, out_valid, out_id, out_lin);
        end
    endtask
    task automatic do_reset();
        reset = 1'b1;
        q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask
    task automatic test_reset();
        req_valid = 4'b0;
        req_log = '0;
        do_reset();
        check_zero("reset");
        idle(2);
    endtask
    task automatic test_single();
        req_log[11:0] = 12'h000;
        drive(4'b0001, 4'b0001);
        idle(4);
        req_log[35:24] = 12'h1FF;
        drive(4'b0100, 4'b0100);
        compared++;
        if (tab_addr !== 8'hFF) begin
            mismatched++;
            $display("FAIL tab_addr got %h want ff", tab_addr);
        end
        idle(4);
        compared++;
        if (out_lin !== 14'h1FF0 || out_id !== 2'd2) begin
            mismatched++;
            $display("FAIL hold got id=%0d lin=%h want id=2 lin=1ff0", out_id, out_lin);
        end
    endtask
    task automatic test_back_to_back();
        req_log[23:12] = 12'hE00;
        drive(4'b0010, 4'b0010);
        req_log[23:12] = 12'hFFF;
        drive(4'b0010, 4'b0010);
        req_log[23:12] = 12'h3A5;
        drive(4'b0010, 4'b0010);
        idle(4);
    endtask
    task automatic test_rotate();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            req_log = {12'(12'h140 + k*17), 12'(12'h2C3 + k*5), 12'(12'h07E + k*33), 12'(12'h511 + k)};
            drive(4'b1111, 4'(1 << (k % 4)));
        end
        idle(4);
    endtask
    task automatic test_drop();
        do_reset();
        req_log = {12'h456, 12'h0, 12'h123, 12'h0};
        drive(4'b1010, 4'b0010);
        drive(4'b1000, 4'b1000);
        drive(4'b1000, 4'b1000);
        drive(4'b1000, 4'b1000);
        idle(4);
    endtask
    task automatic test_reset_mid();
        do_reset();
        req_log = {12'h300, 12'h211, 12'h122, 12'h033};
        drive(4'b1111, 4'b0001);
        drive(4'b1111, 4'b0010);
        #1;
        reset = 1'b1;
        q.delete();
        #1;
        check_zero("reset_mid");
        req_valid = 4'b1111;
        step();
        reset = 1'b0;
        idle(5);
        drive(4'b0110, 4'b0010);
        idle(4);
    endtask
    initial begin
        reset = 1'b1;
        req_valid = 4'b0;
        req_log = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_rotate();
        test_drop();
        test_reset_mid();
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
